// File: rtl/mp_addsub_ctrl_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// default word width, default word count and the controller state encoding.
// REG_WIDTH may be overridden from the command line with `define REG_WIDTH.

`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

package mp_addsub_ctrl_pkg;

   // Width of one word and of the add/sub slice.
   localparam int DEFAULT_REG_WIDTH = `REG_WIDTH;

   // Words per operand.
   localparam int DEFAULT_NWORDS = 4;

   // Controller states. IDLE accepts a request, CALC walks the words LSW first,
   // DONE holds the result until the consumer takes it.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width of the word index counter. It never drops below one bit, so the
   // single-word configuration still has a legal counter.
   function automatic int idx_width(input int nwords);
      if (nwords > 1) begin
         return $clog2(nwords);
      end
      return 1;
   endfunction

endpackage

// File: rtl/mp_addsub_ctrl_addsub_slice.sv
// One REG_WIDTH-wide add/subtract slice with carry-in.
// For subtraction the B word is inverted here; the caller supplies carry-in = 1
// on the least significant word to complete the two's complement.
// Besides the sum and carry-out it reports the carry into the MSB, which the
// sequencer needs to compute signed overflow on the top word.

module mp_addsub_ctrl_addsub_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sub_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o,
   output logic         cmsb_o
);

   logic [W-1:0] b_w;
   logic [W:0]   full_sum;

   // Full-width sum of A, conditionally inverted B and the incoming carry.
   always_comb begin
      b_w      = b_i ^ {W{sub_i}};
      full_sum = {1'b0, a_i} + {1'b0, b_w} + {{W{1'b0}}, cin_i};
   end

   assign sum_o  = full_sum[W-1:0];
   assign cout_o = full_sum[W];

   generate
      if (W > 1) begin : g_wide
         logic [W-1:0] low_sum;

         // Sum of the bits below the MSB; its top bit is the carry into the MSB.
         always_comb begin
            low_sum = {1'b0, a_i[W-2:0]} + {1'b0, b_w[W-2:0]} + {{(W-1){1'b0}}, cin_i};
         end

         assign cmsb_o = low_sum[W-1];
      end else begin : g_single
         // With a one-bit slice the carry into the MSB is the carry-in itself.
         assign cmsb_o = cin_i;
      end
   endgenerate

endmodule

// File: rtl/mp_addsub_ctrl.sv
// Multi-precision add/subtract sequencer for the lab4 ALU.
// Accepts two NWORDS*REG_WIDTH operands in one transaction, walks them LSW
// first through a single REG_WIDTH slice (one word per clock, carry chained
// between words) and presents the full result with carry and overflow flags
// on a valid/ready handshake.
// Optional feature: define MP_ZERO_FLAG_EN to build the zero-flag accumulator;
// without it res_zf_o is tied to 0.

module mp_addsub_ctrl
   import mp_addsub_ctrl_pkg::*;
#(
   parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
   parameter int NWORDS    = DEFAULT_NWORDS
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic                        req_sub_i,
   input  logic [NWORDS*REG_WIDTH-1:0] req_a_i,
   input  logic [NWORDS*REG_WIDTH-1:0] req_b_i,
   output logic                        res_valid_o,
   input  logic                        res_ready_i,
   output logic [NWORDS*REG_WIDTH-1:0] res_data_o,
   output logic                        res_cf_o,
   output logic                        res_ovf_o,
   output logic                        res_zf_o
);

   localparam int TW   = NWORDS * REG_WIDTH;
   localparam int IDXW = idx_width(NWORDS);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

   state_e          state_q;
   logic [IDXW-1:0] idx_q;
   logic [TW-1:0]   a_q;
   logic [TW-1:0]   b_q;
   logic            sub_q;
   logic            carry_q;
   logic [TW-1:0]   part_q;
   logic [TW-1:0]   part_d;
   logic            req_ready_q;
   logic            res_valid_q;
   logic [TW-1:0]   res_data_q;
   logic            res_cf_q;
   logic            res_ovf_q;

   logic [REG_WIDTH-1:0] a_word;
   logic [REG_WIDTH-1:0] b_word;
   logic [REG_WIDTH-1:0] sum_word;
   logic                 slice_cout;
   logic                 slice_cmsb;

   logic accept;

   assign accept = (state_q == ST_IDLE) && req_valid_i && req_ready_q;

   // Select the current operand words and merge the new sum into the partial result.
   always_comb begin
      a_word = a_q[idx_q*REG_WIDTH +: REG_WIDTH];
      b_word = b_q[idx_q*REG_WIDTH +: REG_WIDTH];
      part_d = part_q;
      part_d[idx_q*REG_WIDTH +: REG_WIDTH] = sum_word;
   end

   mp_addsub_ctrl_addsub_slice #(
      .W (REG_WIDTH)
   ) u_slice (
      .a_i    (a_word),
      .b_i    (b_word),
      .sub_i  (sub_q),
      .cin_i  (carry_q),
      .sum_o  (sum_word),
      .cout_o (slice_cout),
      .cmsb_o (slice_cmsb)
   );

   // Controller FSM: accepts a request, runs one word per CALC cycle and holds
   // the registered result in DONE until the consumer takes it. The carry out
   // of the top word only feeds the flags, never the next operation.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         carry_q     <= 1'b0;
         part_q      <= '0;
         req_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_cf_q    <= 1'b0;
         res_ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  a_q         <= req_a_i;
                  b_q         <= req_b_i;
                  sub_q       <= req_sub_i;
                  carry_q     <= req_sub_i;
                  idx_q       <= '0;
                  part_q      <= '0;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_CALC;
               end
            end
            ST_CALC: begin
               part_q  <= part_d;
               carry_q <= slice_cout;
               if (idx_q == LAST_IDX) begin
                  res_data_q  <= part_d;
                  res_cf_q    <= slice_cout;
                  res_ovf_q   <= slice_cmsb ^ slice_cout;
                  res_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               res_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign res_cf_o    = res_cf_q;
   assign res_ovf_o   = res_ovf_q;

`ifdef MP_ZERO_FLAG_EN
   logic zacc_q;
   logic res_zf_q;

   // Sticky zero accumulator: starts set on accept, cleared by any non-zero
   // word, and copied into the flag when the top word completes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         zacc_q   <= 1'b0;
         res_zf_q <= 1'b0;
      end else if (accept) begin
         zacc_q <= 1'b1;
      end else if (state_q == ST_CALC) begin
         zacc_q <= zacc_q & (sum_word == '0);
         if (idx_q == LAST_IDX) begin
            res_zf_q <= zacc_q & (sum_word == '0);
         end
      end
   end

   assign res_zf_o = res_zf_q;
`else
   assign res_zf_o = 1'b0;
`endif

endmodule

// File: tb/tb_mp_addsub_ctrl.sv
// Directed testbench for mp_addsub_ctrl at REG_WIDTH=8, NWORDS=4 (32-bit operands).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_mp_addsub_ctrl;

   localparam int TW = 32;

`ifdef MP_ZERO_FLAG_EN
   localparam logic ZF_EN = 1'b1;
`else
   localparam logic ZF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_sub;
   logic [TW-1:0] req_a;
   logic [TW-1:0] req_b;
   logic          res_valid;
   logic          res_ready;
   logic [TW-1:0] res_data;
   logic          res_cf;
   logic          res_ovf;
   logic          res_zf;

   int checks   = 0;
   int failures = 0;

   mp_addsub_ctrl #(
      .REG_WIDTH (8),
      .NWORDS    (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_sub_i   (req_sub),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_data_o  (res_data),
      .res_cf_o    (res_cf),
      .res_ovf_o   (res_ovf),
      .res_zf_o    (res_zf)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Present one request for a single cycle, then count falling edges until
   // res_valid appears (bounded). lat is counted from the request cycle.
   task automatic applyStimulus(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                input logic s, output int lat);
      @(negedge clk);
      req_a     = a;
      req_b     = b;
      req_sub   = s;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (res_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Complete the result handshake in one cycle.
   task automatic releaseResult();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   // Reset values of every output.
   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 1'b0;
      req_sub   = 1'b0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
      end
      checks++;
      if (res_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid);
      end
      checks++;
      if ({res_data, res_cf, res_ovf, res_zf} !== 35'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got data=%h cf=%b ovf=%b zf=%b expected all 0",
                  res_data, res_cf, res_ovf, res_zf);
      end
      rst = 1'b0;
   endtask

   // Arithmetic vectors: carry chaining, overflow, borrow/wrap, zero result.
   task automatic test_arith();
      logic [TW-1:0] va [7] = '{32'h000000FF, 32'h7FFFFFFF, 32'h00000000, 32'h00000005,
                                32'h80000000, 32'hFFFFFFFF, 32'h12345678};
      logic [TW-1:0] vb [7] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000005,
                                32'h00000001, 32'h00000001, 32'h11111111};
      logic          vs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [TW-1:0] vr [7] = '{32'h00000100, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,
                                32'h7FFFFFFF, 32'h00000000, 32'h23456789};
      logic          vc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic          vo [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic          vz [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL arith%0d_ready_before: got %b expected 1", i, req_ready);
         end
         applyStimulus(va[i], vb[i], vs[i], lat);
         checks++;
         if (lat != 5) begin
            failures++;
            $display("[TB] FAIL arith%0d_latency: got %0d cycles expected 5", i, lat);
         end
         checks++;
         if (res_data !== vr[i]) begin
            failures++;
            $display("[TB] FAIL arith%0d_data: got %h expected %h", i, res_data, vr[i]);
         end
         checks++;
         if (res_cf !== vc[i] || res_ovf !== vo[i]) begin
            failures++;
            $display("[TB] FAIL arith%0d_flags: got cf=%b ovf=%b expected cf=%b ovf=%b",
                     i, res_cf, res_ovf, vc[i], vo[i]);
         end
         checks++;
         if (res_zf !== (vz[i] & ZF_EN)) begin
            failures++;
            $display("[TB] FAIL arith%0d_zf: got %b expected %b", i, res_zf, vz[i] & ZF_EN);
         end
         releaseResult();
         checks++;
         if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL arith%0d_handshake: got valid=%b ready=%b expected valid=0 ready=1",
                     i, res_valid, req_ready);
         end
      end
   endtask

   // Hold off the consumer for 10 cycles while poking req_valid.
   task automatic test_backpressure();
      int lat;
      applyStimulus(32'h12345678, 32'h11111111, 1'b0, lat);
      for (int i = 0; i < 10; i++) begin
         req_a     = 32'hAAAAAAAA;
         req_b     = 32'h55555555;
         req_sub   = 1'b1;
         req_valid = (i % 2 == 0);
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_hold%0d: got valid=%b ready=%b expected valid=1 ready=0",
                     i, res_valid, req_ready);
         end
         checks++;
         if (res_data !== 32'h23456789 || res_cf !== 1'b0 || res_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_stable%0d: got data=%h cf=%b ovf=%b expected 23456789/0/0",
                     i, res_data, res_cf, res_ovf);
         end
      end
      req_valid = 1'b0;
      releaseResult();
      checks++;
      if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1",
                  res_valid, req_ready);
      end
      applyStimulus(32'h00000001, 32'h00000002, 1'b0, lat);
      checks++;
      if (lat != 5 || res_data !== 32'h00000003) begin
         failures++;
         $display("[TB] FAIL bp_next: got lat=%0d data=%h expected lat=5 data=00000003",
                  lat, res_data);
      end
      releaseResult();
   endtask

   // Assert reset during the second CALC cycle, then run a clean operation.
   task automatic test_reset_mid_op();
      int lat;
      @(negedge clk);
      req_a     = 32'h12345678;
      req_b     = 32'h11111111;
      req_sub   = 1'b0;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midrst_state: got valid=%b ready=%b expected valid=0 ready=1",
                  res_valid, req_ready);
      end
      checks++;
      if (res_data !== 32'h0 || res_cf !== 1'b0 || res_ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_outputs: got data=%h cf=%b ovf=%b expected 0",
                  res_data, res_cf, res_ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
      checks++;
      if (lat != 5 || res_data !== 32'h0 || res_cf !== 1'b1 || res_ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_next: got lat=%0d data=%h cf=%b ovf=%b expected 5/00000000/1/0",
                  lat, res_data, res_cf, res_ovf);
      end
      checks++;
      if (res_zf !== ZF_EN) begin
         failures++;
         $display("[TB] FAIL midrst_zf: got %b expected %b", res_zf, ZF_EN);
      end
      releaseResult();
   endtask

   // Three requests queued with req_valid held high and res_ready high.
   task automatic test_back_to_back();
      logic [TW-1:0] ba [3] = '{32'h000000FF, 32'h7FFFFFFF, 32'h00000010};
      logic [TW-1:0] bb [3] = '{32'h00000001, 32'h00000001, 32'h00000020};
      logic          bs [3] = '{1'b0, 1'b0, 1'b1};
      logic [TW-1:0] br [3] = '{32'h00000100, 32'h80000000, 32'hFFFFFFF0};
      logic          bo [3] = '{1'b0, 1'b1, 1'b0};
      int accCyc [3];
      int resCyc [3];
      int sent = 0;
      int nres = 0;
      res_ready = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (res_valid === 1'b1) begin
            checks++;
            if (nres >= 3) begin
               failures++;
               $display("[TB] FAIL b2b_extra: got result %0d data=%h expected only 3", nres, res_data);
            end else begin
               resCyc[nres] = cyc;
               if (res_data !== br[nres] || res_cf !== 1'b0 || res_ovf !== bo[nres]) begin
                  failures++;
                  $display("[TB] FAIL b2b_res%0d: got data=%h cf=%b ovf=%b expected %h/0/%b",
                           nres, res_data, res_cf, res_ovf, br[nres], bo[nres]);
               end
            end
            nres++;
         end
         if (sent < 3) begin
            req_valid = 1'b1;
            req_a     = ba[sent];
            req_b     = bb[sent];
            req_sub   = bs[sent];
            if (req_ready === 1'b1) begin
               accCyc[sent] = cyc;
               sent++;
            end
         end else begin
            req_valid = 1'b0;
         end
      end
      res_ready = 1'b0;
      checks++;
      if (sent != 3 || nres != 3) begin
         failures++;
         $display("[TB] FAIL b2b_count: got accepted=%0d results=%0d expected 3/3", sent, nres);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (resCyc[k] - accCyc[k] != 5) begin
               failures++;
               $display("[TB] FAIL b2b_lat%0d: got %0d expected 5", k, resCyc[k] - accCyc[k]);
            end
         end
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (accCyc[k] - accCyc[k-1] != 6) begin
               failures++;
               $display("[TB] FAIL b2b_spacing%0d: got %0d expected 6", k, accCyc[k] - accCyc[k-1]);
            end
         end
      end
   endtask

   // Run every scenario in order and report.
   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
